fuzz_vector_sequencer: RTL and testbench

- Hardware stimulus and response controller for a fuzz-generated DUT (top: inputs wire3[17:0], wire2[7:0] signed, wire1[21:0], wire0[5:0]; output y[375:0]).
- Replays a loadable table of input vectors into the DUT, one per step, with a programmable settle time per step.
- Compresses each DUT response into a 32-bit MISR signature, so that synthesised and reference netlists are compared by a single word instead of per-cycle strobes.
- Sits between the fuzz harness (loader/comparator) and the DUT.

---
 rtl/fuzz_seq_pkg.sv | 21 ++
 rtl/seq_misr.sv | 41 ++++
 rtl/fuzz_vector_sequencer.sv | 136 +++++++++++++
 tb/tb_fuzz_vector_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_seq_pkg.sv
// Shared constants and types for the fuzz vector sequencer and its MISR.
package fuzz_seq_pkg;

   localparam int unsigned IN_W        = 54;
   localparam int unsigned OUT_W       = 376;
   localparam int unsigned DEPTH       = 32;
   localparam int unsigned AW          = 5;
   localparam int unsigned SIG_W       = 32;
   localparam logic [31:0] SIG_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] SIG_POLY    = 32'h0040_0007;
   localparam int unsigned FOLD_CHUNKS = (OUT_W + SIG_W - 1) / SIG_W;

   typedef enum logic [2:0] {
      StIdle,
      StApply,
      StSettle,
      StCapture,
      StDone
   } state_e;

endpackage

// File: rtl/seq_misr.sv
// Folds the wide DUT response to one word and accumulates it into a 32-bit MISR.
module seq_misr
   import fuzz_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_init,
   input  logic             i_en,
   input  logic [OUT_W-1:0] i_dut_out,
   output logic [SIG_W-1:0] o_sig
);

   logic [FOLD_CHUNKS*SIG_W-1:0] w_ext;
   logic [SIG_W-1:0]             w_fold;
   logic [SIG_W-1:0]             w_next;
   logic [SIG_W-1:0]             r_sig;

   // Zero-extend to a whole number of chunks, then XOR the chunks together.
   always_comb begin
      w_ext  = {{(FOLD_CHUNKS*SIG_W-OUT_W){1'b0}}, i_dut_out};
      w_fold = '0;
      for (int k = 0; k < FOLD_CHUNKS; k++) begin
         w_fold = w_fold ^ w_ext[k*SIG_W +: SIG_W];
      end
   end

   assign w_next = {r_sig[SIG_W-2:0], 1'b0} ^ (r_sig[SIG_W-1] ? SIG_POLY : '0) ^ w_fold;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sig <= '0;
      end else if (i_init) begin
         r_sig <= SIG_INIT;
      end else if (i_en) begin
         r_sig <= w_next;
      end
   end

   assign o_sig = r_sig;

endmodule

// File: rtl/fuzz_vector_sequencer.sv
// Replays a loadable vector table into a fuzz DUT with programmable settle time
// and compresses the responses into a MISR signature.
module fuzz_vector_sequencer
   import fuzz_seq_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load_we,
   input  logic [AW-1:0]    i_load_addr,
   input  logic [IN_W-1:0]  i_load_data,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic [AW:0]      i_num_vec,
   input  logic [3:0]       i_settle,
   output logic [IN_W-1:0]  o_dut_in,
   input  logic [OUT_W-1:0] i_dut_out,
   output logic [AW-1:0]    o_vec_idx,
   output logic             o_busy,
   output logic             o_done,
   output logic [SIG_W-1:0] o_signature
);

   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

   state_e          r_state;
   state_e          w_state_next;
   logic [IN_W-1:0] r_mem [DEPTH];
   logic [IN_W-1:0] r_dut_in;
   logic [AW-1:0]   r_vec_idx;
   logic [AW:0]     r_idx;
   logic [AW:0]     r_count;
   logic [AW:0]     w_count_clamped;
   logic [3:0]      r_settle;
   logic [3:0]      r_settle_cnt;
   logic            w_last;
   logic            w_start_go;
   logic            w_init;
   logic            w_apply;
   logic            w_capture;
   logic            w_abort_run;

   assign w_count_clamped = (i_num_vec > DepthCnt) ? DepthCnt : i_num_vec;
   assign w_start_go      = i_start && !i_abort;
   assign w_abort_run     = i_abort && (r_state != StIdle);
   // idx is one bit wider than the address so a full-depth count never wraps.
   assign w_last          = (r_idx == r_count - (AW+1)'(1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:    if (w_start_go) w_state_next = (w_count_clamped == '0) ? StDone : StApply;
         StApply:   w_state_next = (r_settle == '0) ? StCapture : StSettle;
         StSettle:  if (r_settle_cnt == 4'd1) w_state_next = StCapture;
         StCapture: w_state_next = w_last ? StDone : StApply;
         StDone:    w_state_next = StIdle;
         default:   w_state_next = StIdle;
      endcase
      if (w_abort_run) begin
         w_state_next = StIdle;
      end
   end

   always_comb begin
      o_busy    = 1'b0;
      o_done    = 1'b0;
      w_init    = 1'b0;
      w_apply   = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         StIdle:    w_init = w_start_go;
         StApply:   begin o_busy = 1'b1; w_apply = !i_abort; end
         StSettle:  o_busy = 1'b1;
         StCapture: begin o_busy = 1'b1; w_capture = !i_abort; end
         StDone:    o_done = 1'b1;
         default:   o_busy = 1'b0;
      endcase
   end

   // Table is frozen for the whole run; a write alongside start still lands first.
   always_ff @(posedge i_clk) begin
      if (i_load_we && (r_state == StIdle)) begin
         r_mem[i_load_addr] <= i_load_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dut_in     <= '0;
         r_vec_idx    <= '0;
         r_idx        <= '0;
         r_count      <= '0;
         r_settle     <= '0;
         r_settle_cnt <= '0;
      end else begin
         if (w_init) begin
            r_count  <= w_count_clamped;
            r_settle <= i_settle;
            r_idx    <= '0;
         end
         if (w_abort_run) begin
            r_dut_in <= '0;
         end else if (w_apply) begin
            r_dut_in     <= r_mem[r_idx[AW-1:0]];
            r_vec_idx    <= r_idx[AW-1:0];
            r_settle_cnt <= r_settle;
         end
         if (r_state == StSettle) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
         end
         if (w_capture && !w_last) begin
            r_idx <= r_idx + (AW+1)'(1);
         end
      end
   end

   seq_misr u_misr (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_init    (w_init),
      .i_en      (w_capture),
      .i_dut_out (i_dut_out),
      .o_sig     (o_signature)
   );

   assign o_dut_in  = r_dut_in;
   assign o_vec_idx = r_vec_idx;

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Self-checking bench: table-driven runs, hand-written reset/abort sequences and
// randomized runs against a bit-level behavioural model of the sequencer.
module tb_fuzz_vector_sequencer;

   logic         clk;
   logic         rst_n;
   logic         load_we;
   logic [4:0]   load_addr;
   logic [53:0]  load_data;
   logic         start;
   logic         abort;
   logic [5:0]   num_vec;
   logic [3:0]   settle;
   logic [53:0]  dut_in;
   logic [375:0] dut_out;
   logic [4:0]   vec_idx;
   logic         busy;
   logic         done;
   logic [31:0]  signature;

   int           errors;
   int           checks;
   logic [53:0]  tb_mem [32];
   logic [375:0] salt;
   int           mode;

   typedef struct {
      string       name;
      int          num;
      int          st;
      int          md;
      logic        ld0;
      logic        use_model;
      logic [31:0] exp_sig;
   } vec_t;

   vec_t tbl[6];

   fuzz_vector_sequencer dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_load_we   (load_we),
      .i_load_addr (load_addr),
      .i_load_data (load_data),
      .i_start     (start),
      .i_abort     (abort),
      .i_num_vec   (num_vec),
      .i_settle    (settle),
      .o_dut_in    (dut_in),
      .i_dut_out   (dut_out),
      .o_vec_idx   (vec_idx),
      .o_busy      (busy),
      .o_done      (done),
      .o_signature (signature)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for the fuzz DUT: response is a fixed pattern or a function of its input.
   function automatic logic [375:0] resp(input logic [53:0] v, input int md);
      logic [377:0] rep;
      if (md == 0) return '0;
      if (md == 1) return '1;
      rep = {7{v}};
      return rep[375:0] ^ salt;
   endfunction

   function automatic logic [31:0] fold(input logic [375:0] y);
      logic [31:0] f;
      f = '0;
      for (int i = 0; i < 376; i++) f[i % 32] = f[i % 32] ^ y[i];
      return f;
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
      return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
   endfunction

   always_comb dut_out = resp(dut_in, mode);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic load_table();
      for (int a = 0; a < 32; a++) begin
         tb_mem[a] = {$urandom, $urandom};
         load_we   = 1'b1;
         load_addr = 5'(a);
         load_data = tb_mem[a];
         tick();
      end
      load_we = 1'b0;
   endtask

   task automatic run(input string nm, input int num, input int st, input int md,
                      input logic ld0, input logic use_model, input logic [31:0] exp_fixed,
                      input logic poke);
      int          cnt;
      int          per;
      int          n;
      logic [31:0] exp_sig;
      mode = md;
      cnt  = (num > 32) ? 32 : num;
      per  = st + 2;
      n    = cnt * per;
      if (ld0) tb_mem[0] = 54'h1;
      exp_sig = 32'hFFFF_FFFF;
      for (int v = 0; v < cnt; v++) exp_sig = misr_step(exp_sig, fold(resp(tb_mem[v], md)));
      if (!use_model) exp_sig = exp_fixed;
      start   = 1'b1;
      num_vec = 6'(num);
      settle  = 4'(st);
      if (ld0) begin
         load_we   = 1'b1;
         load_addr = 5'd0;
         load_data = 54'h1;
      end
      tick();
      start   = 1'b0;
      load_we = 1'b0;
      for (int e = 1; e <= n; e++) begin
         if (poke && e == 2 && cnt > 1) begin
            start     = 1'b1;
            load_we   = 1'b1;
            load_addr = 5'(cnt - 1);
            load_data = ~tb_mem[cnt - 1];
         end
         tick();
         start   = 1'b0;
         load_we = 1'b0;
         chk({nm, " dut_in"}, 64'(dut_in), 64'(tb_mem[(e - 1) / per]));
         chk({nm, " vec_idx"}, 64'(vec_idx), 64'((e - 1) / per));
         if (e < n) chk({nm, " busy/done mid-run"}, 64'({busy, done}), 64'(2'b10));
      end
      chk({nm, " done pulse, busy low"}, 64'({busy, done}), 64'(2'b01));
      chk({nm, " signature"}, 64'(signature), 64'(exp_sig));
      tick();
      chk({nm, " done one cycle"}, 64'({busy, done}), 64'(2'b00));
      chk({nm, " signature held"}, 64'(signature), 64'(exp_sig));
   endtask

   task automatic check_zero_outputs(input string nm);
      chk({nm, " dut_in"}, 64'(dut_in), 64'(0));
      chk({nm, " vec_idx"}, 64'(vec_idx), 64'(0));
      chk({nm, " busy/done"}, 64'({busy, done}), 64'(0));
      chk({nm, " signature"}, 64'(signature), 64'(0));
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_sig;
      errors    = 0;
      checks    = 0;
      mode      = 0;
      salt      = '0;
      rst_n     = 1'b0;
      load_we   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      abort     = 1'b0;
      num_vec   = '0;
      settle    = '0;
      #23;
      check_zero_outputs("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 3; i++) salt[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      load_table();

      tbl[0] = '{"zero resp",     1,  0, 0, 1'b1, 1'b0, 32'hFFBF_FFF9};
      tbl[1] = '{"ones resp",     1,  0, 1, 1'b0, 1'b0, 32'h00BF_FFF9};
      tbl[2] = '{"count zero",    0,  5, 0, 1'b0, 1'b0, 32'hFFFF_FFFF};
      tbl[3] = '{"three vectors", 3,  2, 2, 1'b0, 1'b1, 32'h0};
      tbl[4] = '{"clamp 40",      40, 1, 2, 1'b0, 1'b1, 32'h0};
      tbl[5] = '{"full depth",    32, 0, 2, 1'b0, 1'b1, 32'h0};
      for (int t = 0; t < 6; t++) begin
         run(tbl[t].name, tbl[t].num, tbl[t].st, tbl[t].md, tbl[t].ld0, tbl[t].use_model,
             tbl[t].exp_sig, 1'b1);
      end

      // Reset mid-run at settle=3: outputs clear at once, no done afterwards.
      mode    = 2;
      start   = 1'b1;
      num_vec = 6'd3;
      settle  = 4'd3;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      #2 rst_n = 1'b0;
      #1;
      check_zero_outputs("async reset");
      #4 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("post-reset idle", 64'({busy, done}), 64'(0));
      end

      // Abort during the second vector's settle phase.
      start   = 1'b1;
      num_vec = 6'd3;
      settle  = 4'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("abort pre busy", 64'(busy), 64'(1));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_sig = misr_step(32'hFFFF_FFFF, fold(resp(tb_mem[0], 2)));
      chk("abort busy/done", 64'({busy, done}), 64'(0));
      chk("abort dut_in", 64'(dut_in), 64'(0));
      chk("abort signature", 64'(signature), 64'(exp_sig));
      tick();
      chk("abort no done", 64'({busy, done}), 64'(0));

      // Start and abort together in idle: abort wins.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("start+abort idle", 64'({busy, done}), 64'(0));
      tick();
      chk("start+abort stays idle", 64'({busy, done}), 64'(0));
      run("after abort", 3, 2, 2, 1'b0, 1'b1, 32'h0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 3; i++) salt[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
         load_table();
         run($sformatf("random run %0d", r), int'($urandom_range(0, 40)),
             int'($urandom_range(0, 15)), 2, 1'b0, 1'b1, 32'h0, 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
